// File: rtl/bp_pkg.sv
// Shared types and helpers for the global branch predictor: 2-bit counter
// encodings, scheduler FSM states and the saturating counter update.
package bp_pkg;

  localparam int IDX_W_DEF  = 10;
  localparam int HIST_W_DEF = 10;

  // Gray-style encoding: bit[1] is the predicted direction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b11,
    ST  = 2'b10
  } cnt_e;

  typedef enum logic [1:0] {
    S_INIT  = 2'b00,
    S_IDLE  = 2'b01,
    S_WAIT  = 2'b10,
    S_WRITE = 2'b11
  } sched_state_e;

  function automatic logic [1:0] next_cnt(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    case (cnt)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = cnt;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count; push is dropped when full and
// pop is ignored when empty. Pointers wrap modulo DEPTH (power of two).
module sync_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]          r_mem [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [$clog2(DEPTH):0] r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign o_full    = (r_count == ($clog2(DEPTH)+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; only entries below the count are ever read out.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

endmodule

// File: rtl/pht_update_scheduler.sv
// Owns the single PHT port: post-reset init sweep, lookup-priority arbitration
// and buffered read-modify-write of 2-bit counters for resolved branches.
module pht_update_scheduler
  import bp_pkg::*;
#(
  parameter int IDX_W      = IDX_W_DEF,
  parameter int HIST_W     = HIST_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lookup_req,
  input  logic [IDX_W-1:0]  lookup_idx,
  output logic              lookup_grant,
  input  logic              res_valid,
  input  logic [31:0]       res_pc,
  input  logic [HIST_W-1:0] res_hist,
  input  logic              res_taken,
  input  logic              res_pred,
  output logic              res_ready,
  output logic              pht_en,
  output logic              pht_we,
  output logic [IDX_W-1:0]  pht_addr,
  output logic [1:0]        pht_wdata,
  input  logic [1:0]        pht_rdata,
  output logic              init_busy,
  output logic              mispredict,
  output logic [HIST_W-1:0] hist_restore
);

  localparam int FW = IDX_W + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  sched_state_e        r_state;
  logic [IDX_W-1:0]    r_sweep;
  logic [1:0]          r_cnt;
  logic                r_mispredict;
  logic [HIST_W-1:0]   r_hist_restore;

  logic                w_accept;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [CW-1:0]       w_count;
  logic [FW-1:0]       w_push_data;
  logic [FW-1:0]       w_head;
  logic [IDX_W-1:0]    w_head_idx;
  logic                w_head_taken;
  logic                w_unused;

  assign init_busy    = (r_state == S_INIT);
  assign lookup_grant = lookup_req & ~init_busy;
  assign res_ready    = ~init_busy & ~w_full;
  assign w_accept     = res_valid & res_ready;
  assign w_pop        = (r_state == S_WRITE) & ~lookup_req;
  assign w_push_data  = {res_pc[IDX_W+1:2] ^ res_hist[IDX_W-1:0], res_taken};
  assign w_head_idx   = w_head[FW-1:1];
  assign w_head_taken = w_head[0];
  assign mispredict   = r_mispredict;
  assign hist_restore = r_hist_restore;
  assign w_unused     = ^{res_pc[31:IDX_W+2], res_pc[1:0], w_count};

  sync_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_accept),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Sequencer: sweep, then read / capture / write-back of the FIFO head.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
      r_sweep <= '0;
      r_cnt   <= 2'b00;
    end else begin
      case (r_state)
        S_INIT: begin
          r_sweep <= r_sweep + IDX_W'(1);
          if (r_sweep == {IDX_W{1'b1}}) begin
            r_state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (~w_empty && ~lookup_req) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // The IDLE read lands now even if a lookup owns the port this cycle.
          r_cnt   <= pht_rdata;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          if (~lookup_req) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  // Mispredict pulse and corrected history, one cycle after the accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mispredict   <= 1'b0;
      r_hist_restore <= '0;
    end else begin
      r_mispredict <= w_accept & (res_taken != res_pred);
      if (w_accept && (res_taken != res_pred)) begin
        r_hist_restore <= {res_hist[HIST_W-2:0], res_taken};
      end
    end
  end

  // Port mux: sweep owns it in INIT, otherwise a lookup always wins.
  always_comb begin
    pht_en    = 1'b0;
    pht_we    = 1'b0;
    pht_addr  = '0;
    pht_wdata = 2'b00;
    if (r_state == S_INIT) begin
      pht_en    = 1'b1;
      pht_we    = 1'b1;
      pht_addr  = r_sweep;
      pht_wdata = WT;
    end else if (lookup_grant) begin
      pht_en   = 1'b1;
      pht_addr = lookup_idx;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (~w_empty) begin
            pht_en   = 1'b1;
            pht_addr = w_head_idx;
          end else begin
            pht_en = 1'b0;
          end
        end
        S_WRITE: begin
          pht_en    = 1'b1;
          pht_we    = 1'b1;
          pht_addr  = w_head_idx;
          pht_wdata = next_cnt(r_cnt, w_head_taken);
        end
        default: begin
          pht_en = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pht_update_scheduler.sv
// Bench for pht_update_scheduler: PHT memory model, reference counter table
// and pending-update queue, directed scenarios followed by random traffic.
module tb_pht_update_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_req;
  logic [9:0]  lookup_idx;
  logic        lookup_grant;
  logic        res_valid;
  logic [31:0] res_pc;
  logic [9:0]  res_hist;
  logic        res_taken;
  logic        res_pred;
  logic        res_ready;
  logic        pht_en;
  logic        pht_we;
  logic [9:0]  pht_addr;
  logic [1:0]  pht_wdata;
  logic [1:0]  pht_rdata = 2'b00;
  logic        init_busy;
  logic        mispredict;
  logic [9:0]  hist_restore;

  always #5 clk = ~clk;

  pht_update_scheduler dut (
    .clk(clk), .rst(rst),
    .lookup_req(lookup_req), .lookup_idx(lookup_idx), .lookup_grant(lookup_grant),
    .res_valid(res_valid), .res_pc(res_pc), .res_hist(res_hist),
    .res_taken(res_taken), .res_pred(res_pred), .res_ready(res_ready),
    .pht_en(pht_en), .pht_we(pht_we), .pht_addr(pht_addr),
    .pht_wdata(pht_wdata), .pht_rdata(pht_rdata),
    .init_busy(init_busy), .mispredict(mispredict), .hist_restore(hist_restore)
  );

  // Single-port PHT: read data appears the cycle after the read.
  logic [1:0] mem [1024];
  always @(posedge clk) begin
    if (pht_en) begin
      if (pht_we) mem[pht_addr] <= pht_wdata;
      else        pht_rdata <= mem[pht_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: strength level 0..3 per entry, encoded back to the PHT bits.
  logic [1:0] lvl_enc [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int         ref_lvl [1024];
  int         q_idx [$];
  bit         q_tk  [$];
  bit         exp_init = 1'b1;
  int         exp_sweep = 0;
  bit         exp_mp = 1'b0;
  logic [9:0] exp_hr = '0;
  logic [1:0] last_wr = 2'b00;
  int         n_upd_writes = 0;

  always @(negedge clk) begin
    bit rdy_exp;
    int lv;
    if (rst) begin
      q_idx.delete();
      q_tk.delete();
      exp_init  = 1'b1;
      exp_sweep = 0;
      exp_mp    = 1'b0;
      for (int i = 0; i < 1024; i++) ref_lvl[i] = 2;
    end else begin
      check("mispredict", 32'(mispredict), 32'(exp_mp));
      if (exp_mp) check("hist_restore", 32'(hist_restore), 32'(exp_hr));
      rdy_exp = !exp_init && (q_idx.size() < 4);
      check("res_ready", 32'(res_ready), 32'(rdy_exp));
      check("init_busy", 32'(init_busy), 32'(exp_init));
      if (exp_init) begin
        check("grant_in_sweep", 32'(lookup_grant), 32'(0));
        check("sweep_port", 32'({pht_en, pht_we, pht_addr, pht_wdata}),
              32'({1'b1, 1'b1, exp_sweep[9:0], 2'b11}));
        exp_sweep++;
        if (exp_sweep == 1024) exp_init = 1'b0;
      end else begin
        check("lookup_grant", 32'(lookup_grant), 32'(lookup_req));
        if (lookup_req) begin
          check("lookup_port", 32'({pht_en, pht_we, pht_addr}), 32'({1'b1, 1'b0, lookup_idx}));
        end else if (pht_en && pht_we) begin
          if (q_idx.size() == 0) begin
            check("write_without_pending", 32'(pht_we), 32'(0));
          end else begin
            lv = ref_lvl[q_idx[0]];
            lv = q_tk[0] ? ((lv == 3) ? 3 : lv + 1) : ((lv == 0) ? 0 : lv - 1);
            ref_lvl[q_idx[0]] = lv;
            check("write_addr", 32'(pht_addr), 32'(q_idx[0]));
            check("write_data", 32'(pht_wdata), 32'(lvl_enc[lv]));
            last_wr = pht_wdata;
            n_upd_writes++;
            void'(q_idx.pop_front());
            void'(q_tk.pop_front());
          end
        end else if (pht_en) begin
          if (q_idx.size() == 0) check("read_without_pending", 32'(pht_en), 32'(0));
          else check("read_addr", 32'(pht_addr), 32'(q_idx[0]));
        end
      end
      exp_mp = 1'b0;
      if (res_valid && rdy_exp) begin
        q_idx.push_back(int'(res_pc[11:2] ^ res_hist));
        q_tk.push_back(res_taken);
        exp_mp = (res_taken != res_pred);
        if (exp_mp) exp_hr = {res_hist[8:0], res_taken};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q_idx.size() != 0; i++) tick();
    tick();
    check("drain_empty", 32'(q_idx.size()), 32'(0));
  endtask

  task automatic send(input logic [31:0] pc, input logic [9:0] h, input logic tk, input logic pr);
    res_valid = 1'b1; res_pc = pc; res_hist = h; res_taken = tk; res_pred = pr;
    tick();
    res_valid = 1'b0;
  endtask

  logic [1:0] sat_exp [4] = '{2'b11, 2'b01, 2'b00, 2'b00};
  int acc;
  int wr_before;

  initial begin
    rst = 1'b1; lookup_req = 1'b1; lookup_idx = 10'h155;
    res_valid = 1'b0; res_pc = '0; res_hist = '0; res_taken = 1'b0; res_pred = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("rst_init_busy", 32'(init_busy), 32'(1));
    check("rst_ready_grant", 32'({res_ready, lookup_grant, mispredict}), 32'(0));
    check("rst_hist_restore", 32'(hist_restore), 32'(0));
    check("rst_port", 32'({pht_en, pht_we, pht_addr, pht_wdata}), 32'({1'b1, 1'b1, 10'd0, 2'b11}));
    tick();
    rst = 1'b0;
    repeat (1023) @(posedge clk);
    @(negedge clk);
    check("busy_last_sweep", 32'(init_busy), 32'(1));
    @(negedge clk);
    check("busy_cycle_1025", 32'(init_busy), 32'(0));
    tick();
    lookup_req = 1'b0;

    // Best-case single update: read at t+1, write at t+3.
    send(32'h40, 10'h003, 1'b1, 1'b1);
    @(negedge clk);
    check("single_read", 32'({pht_en, pht_we, pht_addr}), 32'({1'b1, 1'b0, 10'h013}));
    tick(); tick();
    @(negedge clk);
    check("single_write", 32'({pht_en, pht_we, pht_addr, pht_wdata}),
          32'({1'b1, 1'b1, 10'h013, 2'b10}));
    drain();

    // Mispredict pulse with corrected history.
    send(32'h0, 10'h155, 1'b1, 1'b0);
    @(negedge clk);
    check("mp_pulse", 32'({mispredict, hist_restore}), 32'({1'b1, 10'h2AB}));
    tick();
    @(negedge clk);
    check("mp_one_cycle", 32'(mispredict), 32'(0));
    drain();

    // Five back-to-back with lookups holding the port.
    lookup_req = 1'b1;
    wr_before = n_upd_writes;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      lookup_idx = 10'($urandom);
      res_valid = 1'b1; res_pc = 32'($urandom_range(0, 63)) << 2;
      res_hist = 10'($urandom); res_taken = 1'($urandom); res_pred = res_taken;
      @(negedge clk);
      if (res_ready) acc++;
      tick();
    end
    res_valid = 1'b0;
    check("accepts_when_full", 32'(acc), 32'(4));
    repeat (5) tick();
    check("no_write_under_lookup", 32'(n_upd_writes), 32'(wr_before));
    lookup_req = 1'b0;
    drain();
    check("four_written", 32'(n_upd_writes - wr_before), 32'(4));

    // Saturation toward not-taken from ST.
    send(32'h2A0 << 2, 10'h000, 1'b1, 1'b1);
    drain();
    for (int i = 0; i < 4; i++) begin
      send(32'h2A0 << 2, 10'h000, 1'b0, 1'b0);
      drain();
      check("sat_seq", 32'(last_wr), 32'(sat_exp[i]));
    end

    // Reset while a write is held off by a lookup.
    send(32'h100, 10'h001, 1'b1, 1'b1);
    tick();
    lookup_req = 1'b1;
    tick(); tick();
    wr_before = n_upd_writes;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", 32'({init_busy, res_ready}), 32'({1'b1, 1'b0}));
    check("rst_mid_addr", 32'(pht_addr), 32'(0));
    repeat (1030) tick();
    check("pending_write_dropped", 32'(n_upd_writes), 32'(wr_before));
    check("fifo_cleared", 32'(q_idx.size()), 32'(0));
    lookup_req = 1'b0;

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      lookup_req = ($urandom_range(0, 9) < 3);
      lookup_idx = 10'($urandom);
      res_valid  = ($urandom_range(0, 1) == 1);
      res_pc     = 32'($urandom_range(0, 15)) << 2;
      res_hist   = 10'($urandom_range(0, 7));
      res_taken  = 1'($urandom);
      res_pred   = 1'($urandom);
      tick();
    end
    lookup_req = 1'b0;
    res_valid  = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pht_update_scheduler.md
# pht_update_scheduler

Owns the single port of the pattern history table (PHT) used by the global branch predictor. It sequences the post-reset PHT initialisation sweep and arbitrates between fetch-stage lookups and M-stage counter updates. It buffers resolved branches, performs read-modify-write of 2-bit counters, and raises a registered mispredict pulse with the corrected global history.

## Interface
Parameters:
- IDX_W, 10, PHT index width; PHT depth is 2^IDX_W
- HIST_W, 10, global history width (equal to IDX_W)
- FIFO_DEPTH, 4, resolved-branch buffer entries (power of two)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- lookup_req  in  1  F stage wants the PHT port this cycle
- lookup_idx  in  IDX_W  F-stage index (pcF[IDX_W+1:2] ^ GHT)
- lookup_grant  out  1  lookup owns the port this cycle
- res_valid  in  1  branch resolved in M
- res_pc  in  32  pcM
- res_hist  in  HIST_W  architectural history before this branch
- res_taken  in  1  actual direction
- res_pred  in  1  predicted direction
- res_ready  out  1  buffer can accept; M stalls while res_valid & ~res_ready
- pht_en, pht_we  out  1 each  PHT enable / write enable
- pht_addr  out  IDX_W  PHT address
- pht_wdata  out  2  counter to write
- pht_rdata  in  2  PHT read data, valid the cycle after a read
- init_busy  out  1  sweep in progress; pipeline holds F
- mispredict  out  1  one-cycle pulse
- hist_restore  out  HIST_W  corrected history, valid with mispredict

## Operation
- Counter encoding: SNT=00, WNT=01, WT=11, ST=10; predict taken = bit[1].
- Taken: SNT→WNT→WT→ST, ST saturates. Not-taken: ST→WT→WNT→SNT, SNT saturates.
- Accept: res_valid & res_ready. On accept, push {idx = res_pc[IDX_W+1:2] ^ res_hist, taken} into the FIFO.
- Mispredict: on accept with res_taken != res_pred, register mispredict=1 and hist_restore = {res_hist[HIST_W-2:0], res_taken}.
- FSM states:
  - INIT: pht_en=pht_we=1, pht_wdata=WT, addr = sweep counter 0..2^IDX_W-1, one entry per cycle. After the last address → IDLE.
  - IDLE: if FIFO non-empty and ~lookup_req, issue a read at the head index → WAIT.
  - WAIT: capture pht_rdata into cnt_r → WRITE.
  - WRITE: if ~lookup_req, write next(cnt_r, head.taken) at the head index, pop → IDLE. Otherwise hold in WRITE.
- Port priority: a lookup wins in every state except INIT. lookup_grant = lookup_req & ~init_busy. The port drives lookup_idx with pht_we=0.
- In WAIT, a granted lookup drives the port, but the read issued in IDLE is still captured.
- A lookup hitting an index that is being updated returns the pre-update value; no bypass.
- res_ready = ~init_busy & (count < FIFO_DEPTH). No same-cycle pass-through when full.

## Timing
- Reset values: FSM=INIT, sweep=0, FIFO empty, init_busy=1, res_ready=0, lookup_grant=0, mispredict=0, hist_restore=0, pht_en=1, pht_we=1, pht_addr=0, pht_wdata=WT.
- Sweep: 2^IDX_W cycles after rst deasserts. init_busy falls on the cycle after the last write.
- mispredict asserts exactly 1 cycle after the accepting edge and lasts 1 cycle.
- Best-case update: accept at edge t, read at cycle t+1, write at cycle t+3. Each cycle of lookup_req in IDLE or WRITE adds 1 cycle.
- rst asserted mid-sweep or mid-RMW: everything returns to reset values and the sweep restarts at 0. Buffered updates are discarded.
- Push and pop in the same cycle: count is unchanged and both take effect.
- Pointers wrap modulo FIFO_DEPTH.

## Structure
- Package bp_pkg holds:
  - counter encodings SNT/WNT/WT/ST
  - IDX_W/HIST_W defaults
  - function next_cnt(cnt, taken)
  - FSM state enum
- Sub-module: sync_fifo (width IDX_W+1, depth FIFO_DEPTH, push/pop/full/empty/count).
- FSM, arbitration and mispredict register live in the top module.

## Test plan
- Reset then idle: exactly 1024 writes of 2'b11 to addresses 0..1023. init_busy=0 at cycle 1025. lookup_grant stays 0 throughout the sweep even with lookup_req=1.
- Single update, res_pc=0x40, res_hist=0x003, taken=1, PHT[0x013]=WT: read 0x013 at t+1, write 2'b10 at t+3, mispredict stays 0 when res_pred=1.
- Mispredict with res_hist=0x155, taken=1, pred=0: mispredict=1 for one cycle at t+1 with hist_restore=0x2AB.
- Five back-to-back accepts with lookup_req held high: res_ready drops after 4 accepts. No PHT write occurs until lookup_req falls. All 4 updates are then written in FIFO order.
- Saturation: four not-taken updates to one index from ST give the sequence WT, WNT, SNT, SNT.
- rst pulsed during a WRITE state: FIFO empties, the sweep restarts at address 0, and the pending write never occurs.
